// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//
// Decode-to-execute pipeline register. It sits directly downstream of the
// 16-entry register file.
//
// Operand resolve:
//   Each source reads as zero for R0. If the writeback port is writing the
//   same register this cycle, the source takes the writeback data. Otherwise
//   it takes the register-file read data. Register-file writes only land at
//   the clock edge, so the bypass covers the same-cycle write.
//
// Load-use hazard:
//   A load sitting in EX whose destination is read by the decode instruction
//   injects exactly one bubble and raises stall. By the time the held
//   instruction is re-presented, the load data is on the writeback port and
//   the bypass supplies it.
//
// Ports:
//   clk, rst                      clock; synchronous active-low reset
//   id_*                          decode-slot instruction fields and controls
//   rf_data1/2                    register-file read data for id_src1/2
//   wb_we/wb_dst/wb_data          writeback port, mirrored from the regfile
//   flush                         redirect: kill the decode instruction
//   stall                         combinational hold request to PC and IF/ID
//   ex_*                          registered EX-slot instruction
//   bubble_cnt                    saturating count of load-use bubbles
// ----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int unsigned DW = 16,
    parameter int unsigned RW = 4,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,

    // Decode slot
    input  logic          id_valid,
    input  logic [RW-1:0] id_src1,
    input  logic [RW-1:0] id_src2,
    input  logic          id_uses_src1,
    input  logic          id_uses_src2,
    input  logic [RW-1:0] id_dst,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic [2:0]    id_flag_we,
    input  logic [3:0]    id_opcode,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] id_pc,

    // Register-file read data
    input  logic [DW-1:0] rf_data1,
    input  logic [DW-1:0] rf_data2,

    // Writeback port
    input  logic          wb_we,
    input  logic [RW-1:0] wb_dst,
    input  logic [DW-1:0] wb_data,

    input  logic          flush,
    output logic          stall,

    // EX slot
    output logic          ex_valid,
    output logic [DW-1:0] ex_op1,
    output logic [DW-1:0] ex_op2,
    output logic [RW-1:0] ex_dst,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic [2:0]    ex_flag_we,
    output logic [3:0]    ex_opcode,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_pc,

    output logic [CW-1:0] bubble_cnt
);

    // ------------------------------------------------------------------------
    // Pipeline register state
    // ------------------------------------------------------------------------
    logic          ex_valid_q,     ex_valid_d;
    logic [DW-1:0] ex_op1_q,       ex_op1_d;
    logic [DW-1:0] ex_op2_q,       ex_op2_d;
    logic [RW-1:0] ex_dst_q,       ex_dst_d;
    logic          ex_reg_write_q, ex_reg_write_d;
    logic          ex_mem_read_q,  ex_mem_read_d;
    logic          ex_mem_write_q, ex_mem_write_d;
    logic [2:0]    ex_flag_we_q,   ex_flag_we_d;
    logic [3:0]    ex_opcode_q,    ex_opcode_d;
    logic [DW-1:0] ex_imm_q,       ex_imm_d;
    logic [DW-1:0] ex_pc_q,        ex_pc_d;
    logic [CW-1:0] bubble_cnt_q,   bubble_cnt_d;

    // ------------------------------------------------------------------------
    // Operand resolve
    // ------------------------------------------------------------------------
    logic [DW-1:0] op1_res;
    logic [DW-1:0] op2_res;

    // R0 is checked first, so a writeback aimed at R0 can never leak through.
    always_comb begin
        op1_res = rf_data1;
        if (id_src1 == '0) begin
            op1_res = '0;
        end else if (wb_we && (wb_dst == id_src1)) begin
            op1_res = wb_data;
        end
    end

    always_comb begin
        op2_res = rf_data2;
        if (id_src2 == '0) begin
            op2_res = '0;
        end else if (wb_we && (wb_dst == id_src2)) begin
            op2_res = wb_data;
        end
    end

    // ------------------------------------------------------------------------
    // Load-use hazard detection
    // ------------------------------------------------------------------------
    logic load_in_ex;
    logic src1_hit;
    logic src2_hit;
    logic hz;

    // A load targeting R0 produces nothing anyone can depend on.
    assign load_in_ex = ex_valid_q && ex_mem_read_q && ex_reg_write_q && (ex_dst_q != '0);
    assign src1_hit   = id_uses_src1 && (id_src1 == ex_dst_q);
    assign src2_hit   = id_uses_src2 && (id_src2 == ex_dst_q);
    assign hz         = id_valid && load_in_ex && (src1_hit || src2_hit);

    // The flush kills the dependent instruction, so holding it would be pointless.
    assign stall      = hz && !flush;

    // ------------------------------------------------------------------------
    // Next-state: capture by default, bubble on flush or hazard
    // ------------------------------------------------------------------------
    always_comb begin
        ex_valid_d     = id_valid;
        ex_op1_d       = op1_res;
        ex_op2_d       = op2_res;
        ex_dst_d       = id_dst;
        ex_reg_write_d = id_valid && id_reg_write;
        ex_mem_read_d  = id_valid && id_mem_read;
        ex_mem_write_d = id_valid && id_mem_write;
        ex_flag_we_d   = id_valid ? id_flag_we : 3'b000;
        ex_opcode_d    = id_opcode;
        ex_imm_d       = id_imm;
        ex_pc_d        = id_pc;
        bubble_cnt_d   = bubble_cnt_q;

        if (flush || hz) begin
            ex_valid_d     = 1'b0;
            ex_op1_d       = '0;
            ex_op2_d       = '0;
            ex_dst_d       = '0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
            ex_mem_write_d = 1'b0;
            ex_flag_we_d   = 3'b000;
            ex_opcode_d    = 4'h0;
            ex_imm_d       = '0;
            ex_pc_d        = '0;
        end

        // Only hazard bubbles are counted; a flush overrides a coincident hazard.
        if (!flush && hz && (bubble_cnt_q != {CW{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + CW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // State register with synchronous active-low reset
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid_q     <= 1'b0;
            ex_op1_q       <= '0;
            ex_op2_q       <= '0;
            ex_dst_q       <= '0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            ex_flag_we_q   <= 3'b000;
            ex_opcode_q    <= 4'h0;
            ex_imm_q       <= '0;
            ex_pc_q        <= '0;
            bubble_cnt_q   <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_op1_q       <= ex_op1_d;
            ex_op2_q       <= ex_op2_d;
            ex_dst_q       <= ex_dst_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_mem_write_q <= ex_mem_write_d;
            ex_flag_we_q   <= ex_flag_we_d;
            ex_opcode_q    <= ex_opcode_d;
            ex_imm_q       <= ex_imm_d;
            ex_pc_q        <= ex_pc_d;
            bubble_cnt_q   <= bubble_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ex_valid     = ex_valid_q;
    assign ex_op1       = ex_op1_q;
    assign ex_op2       = ex_op2_q;
    assign ex_dst       = ex_dst_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_mem_write = ex_mem_write_q;
    assign ex_flag_we   = ex_flag_we_q;
    assign ex_opcode    = ex_opcode_q;
    assign ex_imm       = ex_imm_q;
    assign ex_pc        = ex_pc_q;
    assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed steps followed by a randomized run, all checked against a
// behavioural model of the EX slot. The bubble counter is narrowed to 4 bits
// so saturation is reachable quickly.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int unsigned DW      = 16;
    localparam int unsigned RW      = 4;
    localparam int unsigned CW      = 4;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [RW-1:0] id_src1, id_src2;
    logic          id_uses_src1, id_uses_src2;
    logic [RW-1:0] id_dst;
    logic          id_reg_write, id_mem_read, id_mem_write;
    logic [2:0]    id_flag_we;
    logic [3:0]    id_opcode;
    logic [DW-1:0] id_imm, id_pc;
    logic [DW-1:0] rf_data1, rf_data2;
    logic          wb_we;
    logic [RW-1:0] wb_dst;
    logic [DW-1:0] wb_data;
    logic          flush;
    logic          stall;
    logic          ex_valid;
    logic [DW-1:0] ex_op1, ex_op2;
    logic [RW-1:0] ex_dst;
    logic          ex_reg_write, ex_mem_read, ex_mem_write;
    logic [2:0]    ex_flag_we;
    logic [3:0]    ex_opcode;
    logic [DW-1:0] ex_imm, ex_pc;
    logic [CW-1:0] bubble_cnt;

    id_ex_stage #(
        .DW (DW),
        .RW (RW),
        .CW (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_uses_src1 (id_uses_src1),
        .id_uses_src2 (id_uses_src2),
        .id_dst       (id_dst),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_mem_write (id_mem_write),
        .id_flag_we   (id_flag_we),
        .id_opcode    (id_opcode),
        .id_imm       (id_imm),
        .id_pc        (id_pc),
        .rf_data1     (rf_data1),
        .rf_data2     (rf_data2),
        .wb_we        (wb_we),
        .wb_dst       (wb_dst),
        .wb_data      (wb_data),
        .flush        (flush),
        .stall        (stall),
        .ex_valid     (ex_valid),
        .ex_op1       (ex_op1),
        .ex_op2       (ex_op2),
        .ex_dst       (ex_dst),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_flag_we   (ex_flag_we),
        .ex_opcode    (ex_opcode),
        .ex_imm       (ex_imm),
        .ex_pc        (ex_pc),
        .bubble_cnt   (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the EX slot
    logic          m_valid;
    logic [DW-1:0] m_op1, m_op2;
    logic [RW-1:0] m_dst;
    logic          m_rw, m_mr, m_mw;
    logic [2:0]    m_fwe;
    logic [3:0]    m_opc;
    logic [DW-1:0] m_imm, m_pc;
    int            m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] resolve(input logic [RW-1:0] s, input logic [DW-1:0] rf);
        if (s == 0) return '0;
        if (wb_we && wb_dst == s) return wb_data;
        return rf;
    endfunction

    task automatic model_bubble();
        m_valid = 0; m_op1 = 0; m_op2 = 0; m_dst = 0;
        m_rw = 0; m_mr = 0; m_mw = 0; m_fwe = 0; m_opc = 0; m_imm = 0; m_pc = 0;
    endtask

    // Called at a negedge with inputs already set: checks stall, advances the
    // model by one edge and compares every registered output.
    task automatic step();
        logic hz;
        #1;
        hz = id_valid && m_valid && m_mr && m_rw && (m_dst != 0) &&
             ((id_uses_src1 && id_src1 == m_dst) || (id_uses_src2 && id_src2 == m_dst));
        chk("stall", {31'b0, stall}, {31'b0, hz && !flush});
        if (!rst) begin
            model_bubble();
            m_cnt = 0;
        end else if (flush) begin
            model_bubble();
        end else if (hz) begin
            model_bubble();
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end else begin
            m_valid = id_valid;
            m_op1   = resolve(id_src1, rf_data1);
            m_op2   = resolve(id_src2, rf_data2);
            m_dst   = id_dst;
            m_rw    = id_valid & id_reg_write;
            m_mr    = id_valid & id_mem_read;
            m_mw    = id_valid & id_mem_write;
            m_fwe   = id_valid ? id_flag_we : 3'b0;
            m_opc   = id_opcode;
            m_imm   = id_imm;
            m_pc    = id_pc;
        end
        @(posedge clk);
        #1;
        chk("ex_valid",     {31'b0, ex_valid},     {31'b0, m_valid});
        chk("ex_op1",       {16'b0, ex_op1},       {16'b0, m_op1});
        chk("ex_op2",       {16'b0, ex_op2},       {16'b0, m_op2});
        chk("ex_dst",       {28'b0, ex_dst},       {28'b0, m_dst});
        chk("ex_reg_write", {31'b0, ex_reg_write}, {31'b0, m_rw});
        chk("ex_mem_read",  {31'b0, ex_mem_read},  {31'b0, m_mr});
        chk("ex_mem_write", {31'b0, ex_mem_write}, {31'b0, m_mw});
        chk("ex_flag_we",   {29'b0, ex_flag_we},   {29'b0, m_fwe});
        chk("ex_opcode",    {28'b0, ex_opcode},    {28'b0, m_opc});
        chk("ex_imm",       {16'b0, ex_imm},       {16'b0, m_imm});
        chk("ex_pc",        {16'b0, ex_pc},        {16'b0, m_pc});
        chk("bubble_cnt",   {28'b0, bubble_cnt},   m_cnt[31:0]);
        @(negedge clk);
    endtask

    task automatic clear_in();
        rst = 1; id_valid = 0; id_src1 = 0; id_src2 = 0; id_uses_src1 = 0; id_uses_src2 = 0;
        id_dst = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_flag_we = 0;
        id_opcode = 0; id_imm = 0; id_pc = 0; rf_data1 = 0; rf_data2 = 0;
        wb_we = 0; wb_dst = 0; wb_data = 0; flush = 0;
    endtask

    task automatic set_load_r4();
        clear_in();
        id_valid = 1; id_reg_write = 1; id_mem_read = 1; id_dst = 4;
        id_src1 = 2; id_uses_src1 = 1; id_opcode = 4'h8; id_pc = 16'h0100;
    endtask

    task automatic set_use_src2_r4();
        clear_in();
        id_valid = 1; id_reg_write = 1; id_dst = 6; id_opcode = 4'h1;
        id_src2 = 4; id_uses_src2 = 1; rf_data2 = 16'hDEAD; id_flag_we = 3'b111;
        id_pc = 16'h0102;
    endtask

    initial begin
        model_bubble();
        m_cnt = 0;
        clear_in();
        @(negedge clk);

        // Reset
        rst = 0;
        step();
        step();
        chk("reset_cnt_zero", {28'b0, bubble_cnt}, 32'h0);

        // Plain capture
        clear_in();
        id_valid = 1; id_opcode = 4'h1; id_src1 = 3; id_uses_src1 = 1; rf_data1 = 16'h1234;
        id_dst = 7; id_reg_write = 1; id_imm = 16'hFFF3; id_pc = 16'h0010;
        step();
        chk("capture_op1", {16'b0, ex_op1}, 32'h1234);
        chk("capture_valid", {31'b0, ex_valid}, 32'h1);

        // Bypass
        clear_in();
        id_valid = 1; id_src1 = 5; id_uses_src1 = 1; rf_data1 = 16'hAAAA;
        wb_we = 1; wb_dst = 5; wb_data = 16'h5555;
        step();
        chk("bypass_op1", {16'b0, ex_op1}, 32'h5555);
        clear_in();
        id_valid = 1; id_src1 = 0; id_uses_src1 = 1; rf_data1 = 16'hAAAA;
        wb_we = 1; wb_dst = 0; wb_data = 16'h5555;
        step();
        chk("r0_op1", {16'b0, ex_op1}, 32'h0);

        // Load-use: one bubble, then bypassed load data
        set_load_r4();
        step();
        set_use_src2_r4();
        #1;
        chk("lu_stall", {31'b0, stall}, 32'h1);
        step();
        chk("lu_bubble", {31'b0, ex_valid}, 32'h0);
        chk("lu_cnt", {28'b0, bubble_cnt}, 32'h1);
        set_use_src2_r4();
        wb_we = 1; wb_dst = 4; wb_data = 16'h00F0;
        step();
        chk("lu_op2", {16'b0, ex_op2}, 32'h00F0);

        // Source index matches but is unused: no hazard
        set_load_r4();
        step();
        set_use_src2_r4();
        id_uses_src2 = 0;
        step();
        chk("unused_cnt", {28'b0, bubble_cnt}, 32'h1);

        // Flush together with a hazard, then flush alone
        set_load_r4();
        step();
        set_use_src2_r4();
        flush = 1;
        step();
        chk("flush_hz_cnt", {28'b0, bubble_cnt}, 32'h1);
        set_use_src2_r4();
        id_mem_write = 1;
        flush = 1;
        step();
        chk("flush_ctrl", {26'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_flag_we}, 32'h0);

        // Saturation: 2^CW+3 hazard bubbles
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            set_load_r4();
            step();
            set_use_src2_r4();
            step();
        end
        chk("sat_cnt", {28'b0, bubble_cnt}, 32'hF);

        // Reset asserted during a stall
        set_load_r4();
        step();
        set_use_src2_r4();
        rst = 0;
        step();
        set_use_src2_r4();
        step();
        chk("rst_mid_cnt", {28'b0, bubble_cnt}, 32'h0);

        // Randomized run
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(0, 59) != 0);
            id_valid     = ($urandom_range(0, 4) != 0);
            id_src1      = RW'($urandom_range(0, 5));
            id_src2      = RW'($urandom_range(0, 5));
            id_uses_src1 = $urandom_range(0, 1) == 1;
            id_uses_src2 = $urandom_range(0, 1) == 1;
            id_dst       = RW'($urandom_range(0, 5));
            id_reg_write = ($urandom_range(0, 3) != 0);
            id_mem_read  = $urandom_range(0, 1) == 1;
            id_mem_write = ($urandom_range(0, 3) == 0);
            id_flag_we   = 3'($urandom);
            id_opcode    = 4'($urandom);
            id_imm       = DW'($urandom);
            id_pc        = DW'($urandom);
            rf_data1     = DW'($urandom);
            rf_data2     = DW'($urandom);
            wb_we        = $urandom_range(0, 1) == 1;
            wb_dst       = RW'($urandom_range(0, 5));
            wb_data      = DW'($urandom);
            flush        = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
